// File: rtl/zynq_dpr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zynq_dpr_pkg
// Purpose  : Shared types and constants for the DPR sequencer: FSM state
//            encoding, ICAP sync/desync command words, error codes and
//            helpers for counter sizing and per-byte bit reversal.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package zynq_dpr_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_STREAM = 3'd2,
    S_DESYNC = 3'd3,
    S_FINISH = 3'd4
  } dpr_state_e;

  // Index 0 is written first. The sync preamble has only three words; the
  // fourth slot pads the array to a power of two and is never selected.
  localparam logic [0:3][31:0] c_SYNC_WORDS = {
    32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000, 32'h0000_0000
  };

  localparam logic [0:3][31:0] c_DESYNC_WORDS = {
    32'h3000_8001, 32'h0000_000D, 32'h2000_0000, 32'h2000_0000
  };

  localparam logic [1:0] c_ERR_NONE    = 2'b00;
  localparam logic [1:0] c_ERR_STALL   = 2'b01;
  localparam logic [1:0] c_ERR_OVERLEN = 2'b10;

  // Width needed to hold a payload word count from 0 up to max_words.
  function automatic int words_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

  // Reverse the bit order inside each byte, leaving byte order untouched.
  function automatic logic [31:0] swap_byte_bits(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b + i] = w[8*b + 7 - i];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zynq_dpr_sequencer_icap_if.sv
`default_nettype none
// ============================================================================
// Module   : zynq_icap_if
// Purpose  : Output register stage for the ICAP primitive. Selects either a
//            command constant or a payload word, optionally reverses the bits
//            of each byte, and registers chip-select and data.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_en              - write a word to ICAP next cycle
//            i_sel_payload     - 1 selects i_payload, 0 selects i_const_word
//            i_const_word      - sync/desync command word
//            i_payload         - bitstream payload word
//            o_icap_csib       - registered chip select, active-low
//            o_icap_rdwrb      - direction, constant write (0)
//            o_icap_i          - registered write data
// Revision : 1.0 - initial release
// ============================================================================
module zynq_icap_if
  import zynq_dpr_pkg::*;
#(
  parameter int SWAP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_sel_payload,
  input  logic [31:0] i_const_word,
  input  logic [31:0] i_payload,
  output logic        o_icap_csib,
  output logic        o_icap_rdwrb,
  output logic [31:0] o_icap_i
);

  logic [31:0] w_word;
  logic [31:0] w_word_out;
  logic        r_csib;
  logic [31:0] r_data;

  assign w_word = i_sel_payload ? i_payload : i_const_word;

  generate
    if (SWAP_BITS != 0) begin : g_swap
      assign w_word_out = swap_byte_bits(w_word);
    end else begin : g_pass
      assign w_word_out = w_word;
    end
  endgenerate

  // Data holds its last value while deselected; only csib marks validity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csib <= 1'b1;
      r_data <= 32'h0;
    end else begin
      r_csib <= ~i_en;
      if (i_en) begin
        r_data <= w_word_out;
      end
    end
  end

  assign o_icap_csib  = r_csib;
  assign o_icap_rdwrb = 1'b0;
  assign o_icap_i     = r_data;

endmodule
`default_nettype wire

// File: rtl/zynq_dpr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : zynq_dpr_sequencer
// Purpose  : Runs one partial reconfiguration through ICAP per rising edge of
//            dpr_start: sync preamble, streamed payload, desync postamble,
//            then a done or error pulse. Aborts the payload on a stalled
//            source or on a bitstream longer than MAX_WORDS.
// Ports    : clk_500mhz, rst      - clock, synchronous active-high reset
//            dpr_start            - reconfiguration request (edge-triggered)
//            bs_valid/bs_data/
//            bs_last/bs_ready     - payload word stream (valid/ready)
//            icap_csib/icap_rdwrb/
//            icap_i               - ICAP primitive write interface
//            dpr_busy/dpr_done/
//            dpr_error            - run status
//            err_code             - 00 none, 01 stall, 10 overlength
//            words_written        - payload words written in this/last run
// Revision : 1.0 - initial release
// ============================================================================
module zynq_dpr_sequencer
  import zynq_dpr_pkg::*;
#(
  parameter int MAX_WORDS    = 65536,
  parameter int STALL_CYCLES = 4096,
  parameter int SWAP_BITS    = 1
) (
  input  logic        clk_500mhz,
  input  logic        rst,
  input  logic        dpr_start,
  input  logic        bs_valid,
  input  logic [31:0] bs_data,
  input  logic        bs_last,
  output logic        bs_ready,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  output logic        dpr_busy,
  output logic        dpr_done,
  output logic        dpr_error,
  output logic [1:0]  err_code,
  output logic [16:0] words_written
);

  localparam int c_WW = words_width(MAX_WORDS);
  localparam int c_SW = $clog2(STALL_CYCLES + 1);
  localparam logic [c_WW-1:0] c_MAX_W     = c_WW'(MAX_WORDS);
  localparam logic [c_SW-1:0] c_STALL_LIM = c_SW'(STALL_CYCLES);

  localparam logic [2:0] c_IDLE   = S_IDLE;
  localparam logic [2:0] c_SYNC   = S_SYNC;
  localparam logic [2:0] c_STREAM = S_STREAM;
  localparam logic [2:0] c_DESYNC = S_DESYNC;
  localparam logic [2:0] c_FINISH = S_FINISH;

  logic [2:0]      r_state;
  logic [1:0]      r_idx;
  logic            r_start_d;
  logic [c_SW-1:0] r_stall;
  logic [c_WW-1:0] r_words;
  logic [1:0]      r_err;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic            r_ready;

  logic            w_start_edge;
  logic            w_xfer;
  logic [c_WW-1:0] w_words_inc;
  logic [c_SW-1:0] w_stall_inc;
  logic            w_icap_en;
  logic            w_sel_payload;
  logic [31:0]     w_const_word;

  assign w_start_edge = dpr_start & ~r_start_d;
  assign w_xfer       = (r_state == c_STREAM) & bs_valid & r_ready;
  assign w_words_inc  = (r_words == c_MAX_W) ? r_words : r_words + c_WW'(1);
  assign w_stall_inc  = r_stall + c_SW'(1);

  always_ff @(posedge clk_500mhz) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_idx     <= 2'd0;
      r_start_d <= 1'b0;
      r_stall   <= '0;
      r_words   <= '0;
      r_err     <= c_ERR_NONE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_start_d <= dpr_start;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_start_edge) begin
            r_state <= c_SYNC;
            r_idx   <= 2'd0;
            r_busy  <= 1'b1;
            r_err   <= c_ERR_NONE;
            r_words <= '0;
            r_stall <= '0;
          end
        end
        c_SYNC: begin
          if (r_idx == 2'd2) begin
            r_state <= c_STREAM;
            r_idx   <= 2'd0;
            r_ready <= 1'b1;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        c_STREAM: begin
          if (w_xfer) begin
            r_words <= w_words_inc;
            r_stall <= '0;
            // bs_last is tested first so a last flag on exactly the
            // MAX_WORDS-th word still completes normally.
            if (bs_last) begin
              r_state <= c_DESYNC;
              r_ready <= 1'b0;
            end else if (w_words_inc == c_MAX_W) begin
              r_state <= c_DESYNC;
              r_ready <= 1'b0;
              r_err   <= c_ERR_OVERLEN;
            end
          end else begin
            r_stall <= w_stall_inc;
            if (w_stall_inc == c_STALL_LIM) begin
              r_state <= c_DESYNC;
              r_ready <= 1'b0;
              r_err   <= c_ERR_STALL;
            end
          end
        end
        c_DESYNC: begin
          if (r_idx == 2'd3) begin
            r_state <= c_FINISH;
            r_idx   <= 2'd0;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        c_FINISH: begin
          // Status lands together with the first deselected ICAP cycle,
          // i.e. right after the last desync word leaves the output stage.
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
          r_done  <= (r_err == c_ERR_NONE);
          r_error <= (r_err != c_ERR_NONE);
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign w_icap_en     = (r_state == c_SYNC) | (r_state == c_DESYNC) | w_xfer;
  assign w_sel_payload = (r_state == c_STREAM);
  assign w_const_word  = (r_state == c_SYNC) ? c_SYNC_WORDS[r_idx]
                                             : c_DESYNC_WORDS[r_idx];

  zynq_icap_if #(
    .SWAP_BITS (SWAP_BITS)
  ) u_icap_if (
    .clk           (clk_500mhz),
    .rst           (rst),
    .i_en          (w_icap_en),
    .i_sel_payload (w_sel_payload),
    .i_const_word  (w_const_word),
    .i_payload     (bs_data),
    .o_icap_csib   (icap_csib),
    .o_icap_rdwrb  (icap_rdwrb),
    .o_icap_i      (icap_i)
  );

  assign bs_ready      = r_ready;
  assign dpr_busy      = r_busy;
  assign dpr_done      = r_done;
  assign dpr_error     = r_error;
  assign err_code      = r_err;
  assign words_written = 17'(r_words);

endmodule
`default_nettype wire

// File: tb/tb_zynq_dpr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_zynq_dpr_sequencer
// Purpose  : Directed self-checking bench. Instance A (MAX_WORDS=4,
//            STALL_CYCLES=8, no swap) covers the run sequences; instance B
//            (same limits, swap on) shares the stimulus for bit-swap checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zynq_dpr_sequencer;

  logic clk_500mhz = 1'b0;
  always #5 clk_500mhz = ~clk_500mhz;

  logic        rst;
  logic        dpr_start;
  logic        bs_valid;
  logic [31:0] bs_data;
  logic        bs_last;

  logic        bs_ready_a, icap_csib_a, icap_rdwrb_a, dpr_busy_a, dpr_done_a, dpr_error_a;
  logic [31:0] icap_i_a;
  logic [1:0]  err_code_a;
  logic [16:0] words_written_a;
  logic        bs_ready_b, icap_csib_b, icap_rdwrb_b, dpr_busy_b, dpr_done_b, dpr_error_b;
  logic [31:0] icap_i_b;
  logic [1:0]  err_code_b;
  logic [16:0] words_written_b;

  zynq_dpr_sequencer #(.MAX_WORDS(4), .STALL_CYCLES(8), .SWAP_BITS(0)) u_dut_a (
    .clk_500mhz(clk_500mhz), .rst(rst), .dpr_start(dpr_start),
    .bs_valid(bs_valid), .bs_data(bs_data), .bs_last(bs_last), .bs_ready(bs_ready_a),
    .icap_csib(icap_csib_a), .icap_rdwrb(icap_rdwrb_a), .icap_i(icap_i_a),
    .dpr_busy(dpr_busy_a), .dpr_done(dpr_done_a), .dpr_error(dpr_error_a),
    .err_code(err_code_a), .words_written(words_written_a)
  );

  zynq_dpr_sequencer #(.MAX_WORDS(4), .STALL_CYCLES(8), .SWAP_BITS(1)) u_dut_b (
    .clk_500mhz(clk_500mhz), .rst(rst), .dpr_start(dpr_start),
    .bs_valid(bs_valid), .bs_data(bs_data), .bs_last(bs_last), .bs_ready(bs_ready_b),
    .icap_csib(icap_csib_b), .icap_rdwrb(icap_rdwrb_b), .icap_i(icap_i_b),
    .dpr_busy(dpr_busy_b), .dpr_done(dpr_done_b), .dpr_error(dpr_error_b),
    .err_code(err_code_b), .words_written(words_written_b)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  int   n_done = 0;
  int   n_err = 0;
  int   n_busy_rise = 0;
  logic busy_prev = 1'b0;

  int base_q, base_qb, base_done, base_err, base_rise;
  logic [31:0] pay[8];

  // Collect every word actually written to ICAP and count status pulses.
  always @(negedge clk_500mhz) begin
    if (icap_csib_a === 1'b0) q_a.push_back(icap_i_a);
    if (icap_csib_b === 1'b0) q_b.push_back(icap_i_b);
    if (dpr_done_a === 1'b1) n_done++;
    if (dpr_error_a === 1'b1) n_err++;
    if (dpr_busy_a === 1'b1 && busy_prev !== 1'b1) n_busy_rise++;
    busy_prev = dpr_busy_a;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=no summary expected=bench finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_500mhz);
    #1;
  endtask

  function automatic logic [31:0] get_a(input int i);
    if (i < q_a.size()) return q_a[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] get_b(input int i);
    if (i < q_b.size()) return q_b[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_csib"},   32'(icap_csib_a),     32'd1);
    chk({tag, "_rdwrb"},  32'(icap_rdwrb_a),    32'd0);
    chk({tag, "_icap_i"}, icap_i_a,             32'd0);
    chk({tag, "_ready"},  32'(bs_ready_a),      32'd0);
    chk({tag, "_busy"},   32'(dpr_busy_a),      32'd0);
    chk({tag, "_done"},   32'(dpr_done_a),      32'd0);
    chk({tag, "_error"},  32'(dpr_error_a),     32'd0);
    chk({tag, "_code"},   32'(err_code_a),      32'd0);
    chk({tag, "_words"},  32'(words_written_a), 32'd0);
  endtask

  // Produce a fresh 0->1 edge and confirm the run starts with cleared status.
  task automatic start_run(input string tag);
    base_q    = q_a.size();
    base_qb   = q_b.size();
    base_done = n_done;
    base_err  = n_err;
    base_rise = n_busy_rise;
    dpr_start = 1'b0;
    tick();
    dpr_start = 1'b1;
    tick();
    chk({tag, "_busy_on"},  32'(dpr_busy_a),      32'd1);
    chk({tag, "_code_clr"}, 32'(err_code_a),      32'd0);
    chk({tag, "_words_clr"},32'(words_written_a), 32'd0);
  endtask

  // Offer pay[0..n-1]; valid is raised on every 'every'-th cycle once ready.
  task automatic send(input int n, input bit with_last, input int every, input bit expect_drop);
    int   k = 0;
    int   cyc = 0;
    int   g = 0;
    logic rdy;
    logic v;
    bs_valid = 1'b0;
    while (bs_ready_a !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    chk("ready_rise", 32'(bs_ready_a), 32'd1);
    g = 0;
    while (k < n && g < 100) begin
      v        = ((cyc % every) == 0);
      bs_valid = v;
      bs_data  = pay[k];
      bs_last  = with_last && (k == n - 1);
      rdy      = bs_ready_a;
      tick();
      g++;
      cyc++;
      chk("csib_follow", 32'(icap_csib_a), 32'(!(v && rdy)));
      if (v && rdy) begin
        chk("icap_word", icap_i_a, pay[k]);
        k++;
      end
    end
    bs_valid = 1'b0;
    bs_last  = 1'b0;
    chk("xfer_count", k, n);
    if (expect_drop) chk("ready_drop", 32'(bs_ready_a), 32'd0);
  endtask

  task automatic wait_end(input string tag);
    int g = 0;
    while (dpr_done_a !== 1'b1 && dpr_error_a !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    chk({tag, "_finish_seen"}, 32'(g < 100),        32'd1);
    chk({tag, "_finish_busy"}, 32'(dpr_busy_a),     32'd0);
    chk({tag, "_finish_csib"}, 32'(icap_csib_a),    32'd1);
    tick();
    chk({tag, "_pulse_len"}, 32'(dpr_done_a | dpr_error_a), 32'd0);
  endtask

  task automatic check_stream(input string tag, input int npay);
    logic [31:0] e[11];
    e[0] = 32'hFFFF_FFFF;
    e[1] = 32'hAA99_5566;
    e[2] = 32'h2000_0000;
    for (int i = 0; i < npay; i++) e[3 + i] = pay[i];
    e[3 + npay] = 32'h3000_8001;
    e[4 + npay] = 32'h0000_000D;
    e[5 + npay] = 32'h2000_0000;
    e[6 + npay] = 32'h2000_0000;
    chk({tag, "_len"}, q_a.size() - base_q, 7 + npay);
    for (int i = 0; i < 7 + npay; i++) begin
      chk({tag, "_word"}, get_a(base_q + i), e[i]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    dpr_start = 1'b0;
    bs_valid  = 1'b0;
    bs_data   = 32'h0;
    bs_last   = 1'b0;
    pay[0] = 32'h1111_1111; pay[1] = 32'h2222_2222;
    pay[2] = 32'h3333_3333; pay[3] = 32'h4444_4444;
    pay[4] = 32'h5555_5555; pay[5] = 32'h6666_6666;
    pay[6] = 32'h7777_7777; pay[7] = 32'h8888_8888;
    repeat (3) tick();
    chk_reset_state("reset");
    chk("reset_b_csib", 32'(icap_csib_b), 32'd1);
    rst = 1'b0;
    tick();

    // Normal run: last on the 4th word (also the MAX_WORDS-th word).
    start_run("normal");
    send(4, 1'b1, 1, 1'b1);
    wait_end("normal");
    check_stream("normal", 4);
    chk("normal_words", 32'(words_written_a), 32'd4);
    chk("normal_code",  32'(err_code_a),      32'd0);
    chk("normal_done",  n_done - base_done,   32'd1);
    chk("normal_err",   n_err - base_err,     32'd0);
    // dpr_start stays high: no further run may start.
    repeat (100) tick();
    chk("held_start_runs", n_busy_rise - base_rise, 32'd1);
    chk("held_start_busy", 32'(dpr_busy_a), 32'd0);
    chk("held_start_qlen", q_a.size() - base_q, 32'd11);

    // Bubbles: valid every third cycle.
    start_run("bubble");
    send(3, 1'b1, 3, 1'b1);
    wait_end("bubble");
    check_stream("bubble", 3);
    chk("bubble_words", 32'(words_written_a), 32'd3);
    chk("bubble_code",  32'(err_code_a),      32'd0);
    chk("bubble_err",   n_err - base_err,     32'd0);

    // Stall after two words, with a start edge mid-run that must be ignored.
    start_run("stall");
    send(2, 1'b0, 1, 1'b0);
    dpr_start = 1'b0;
    tick();
    dpr_start = 1'b1;
    tick();
    wait_end("stall");
    check_stream("stall", 2);
    chk("stall_code",  32'(err_code_a),      32'd1);
    chk("stall_words", 32'(words_written_a), 32'd2);
    chk("stall_err",   n_err - base_err,     32'd1);
    chk("stall_done",  n_done - base_done,   32'd0);
    chk("stall_runs",  n_busy_rise - base_rise, 32'd1);

    // Overlength: four words, no last flag; start_run also verifies the
    // stall code is cleared by the new edge.
    start_run("overlen");
    send(4, 1'b0, 1, 1'b1);
    wait_end("overlen");
    check_stream("overlen", 4);
    chk("overlen_code",  32'(err_code_a),      32'd2);
    chk("overlen_words", 32'(words_written_a), 32'd4);
    chk("overlen_err",   n_err - base_err,     32'd1);

    // Bit swap on instance B.
    pay[0] = 32'h0100_0000;
    start_run("swap");
    send(1, 1'b1, 1, 1'b1);
    wait_end("swap");
    chk("swap_a_payload",  get_a(base_q + 3),  32'h0100_0000);
    chk("swap_b_sync1",    get_b(base_qb + 1), 32'h5599_AA66);
    chk("swap_b_sync2",    get_b(base_qb + 2), 32'h0400_0000);
    chk("swap_b_payload",  get_b(base_qb + 3), 32'h8000_0000);
    chk("swap_b_desync0",  get_b(base_qb + 4), 32'h0C00_0180);
    chk("swap_b_done",     32'(dpr_busy_b),    32'd0);

    // Reset mid-STREAM: outputs return to reset values, no desync written.
    start_run("rstmid");
    send(1, 1'b0, 1, 1'b0);
    rst = 1'b1;
    tick();
    chk_reset_state("rstmid");
    tick();
    chk("rstmid_no_desync", q_a.size() - base_q, 32'd4);
    // dpr_start is still high: released reset must see it as an edge.
    rst = 1'b0;
    tick();
    chk("rel_edge_busy", 32'(dpr_busy_a), 32'd1);
    wait_end("rel_edge");
    chk("rel_edge_code",  32'(err_code_a),      32'd1);
    chk("rel_edge_words", 32'(words_written_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
